// File: rtl/pwl_table_writer_if.sv
// Sample/bias input stream of the PWL table writer.
//   in_valid : producer has a word on in_data
//   in_ready : writer can take the word this cycle
//   in_data  : signed breakpoint sample, or the trailing bias word
// master = producer side, slave = pwl_table_writer side.
interface pwl_table_writer_if #(
    parameter int unsigned SampleWidth = 8
) ();
    logic                   in_valid;
    logic                   in_ready;
    logic [SampleWidth-1:0] in_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready
    );
endinterface

// File: rtl/pwl_table_writer.sv
// Runtime loader for the PWL evaluator's coefficient RAMs.
//
// One load session takes N+1 breakpoint samples y[0..N] (N = 2**AddrWidth) followed by one
// bias word. It writes N segment entries {offset = y[k], slope = (y[k+1]-y[k]) << SlopeShift}
// and then the bias word for the captured setting. Every stored field is saturated to its
// width, and any saturation raises the sticky sat_flag_o.
//
// Ports:
//   clk, rst          : clock and synchronous active-high reset
//   start_i           : begin a session (only honoured while idle)
//   start_setting_i   : setting index captured with start_i
//   in_if             : sample/bias stream (slave side)
//   seg_we_o/waddr_o/wdata_o  : segment RAM write port, addr = {setting, k},
//                               data = {offset, slope} with offset in the MSBs
//   bias_we_o/waddr_o/wdata_o : bias RAM write port, addr = setting
//   busy_o            : session in progress
//   done_o            : one-cycle pulse when the bias word has been written
//   sat_flag_o        : a clamp happened in the current or last session
module pwl_table_writer #(
    parameter int unsigned SettingWidth = 1,
    parameter int unsigned AddrWidth    = 2,
    parameter int unsigned SampleWidth  = 8,
    parameter int unsigned OffsetWidth  = 8,
    parameter int unsigned SlopeWidth   = 6,
    parameter int unsigned SlopeShift   = 1,
    parameter int unsigned BiasWidth    = 8
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start_i,
    input  logic [SettingWidth-1:0]           start_setting_i,
    pwl_table_writer_if.slave                 in_if,
    output logic                              seg_we_o,
    output logic [SettingWidth+AddrWidth-1:0] seg_waddr_o,
    output logic [OffsetWidth+SlopeWidth-1:0] seg_wdata_o,
    output logic                              bias_we_o,
    output logic [SettingWidth-1:0]           bias_waddr_o,
    output logic [BiasWidth-1:0]              bias_wdata_o,
    output logic                              busy_o,
    output logic                              done_o,
    output logic                              sat_flag_o
);

    localparam int unsigned DiffWidth  = SampleWidth + 1;
    localparam int unsigned ShiftWidth = DiffWidth + SlopeShift;

    localparam int OffsetMax = (2 ** (OffsetWidth - 1)) - 1;
    localparam int OffsetMin = -(2 ** (OffsetWidth - 1));
    localparam int SlopeMax  = (2 ** (SlopeWidth - 1)) - 1;
    localparam int SlopeMin  = -(2 ** (SlopeWidth - 1));
    localparam int BiasMax   = (2 ** (BiasWidth - 1)) - 1;
    localparam int BiasMin   = -(2 ** (BiasWidth - 1));

    typedef enum logic [1:0] {
        StIdle,
        StFirst,
        StSeg,
        StBias
    } state_e;

    state_e                            state_q;
    logic [SettingWidth-1:0]           setting_q;
    logic [AddrWidth-1:0]              k_q;
    logic signed [SampleWidth-1:0]     prev_q;
    logic                              sat_q;
    logic                              seg_we_q;
    logic [SettingWidth+AddrWidth-1:0] seg_waddr_q;
    logic [OffsetWidth+SlopeWidth-1:0] seg_wdata_q;
    logic                              bias_we_q;
    logic [SettingWidth-1:0]           bias_waddr_q;
    logic [BiasWidth-1:0]              bias_wdata_q;
    logic                              done_q;

    logic                              accept;
    logic signed [SampleWidth-1:0]     sample;
    logic signed [DiffWidth-1:0]       diff;
    logic signed [ShiftWidth-1:0]      slope_full;
    int                                offset_sat;
    int                                slope_sat;
    int                                bias_sat;
    logic                              seg_clamped;
    logic                              bias_clamped;
    logic [OffsetWidth+SlopeWidth-1:0] seg_entry;

    function automatic int clamp(input int v, input int lo, input int hi);
        int r;
        r = v;
        if (v < lo) r = lo;
        if (v > hi) r = hi;
        return r;
    endfunction

    // Ready depends only on the registered state, never on in_valid.
    assign in_if.in_ready = (state_q != StIdle);
    assign accept         = in_if.in_valid & in_if.in_ready;
    assign sample         = $signed(in_if.in_data);

    // Sign-extending casts keep the difference and the shift exact (no wrap).
    assign diff       = DiffWidth'(sample) - DiffWidth'(prev_q);
    assign slope_full = ShiftWidth'(diff) <<< SlopeShift;

    always_comb begin
        offset_sat   = clamp(int'(prev_q), OffsetMin, OffsetMax);
        slope_sat    = clamp(int'(slope_full), SlopeMin, SlopeMax);
        bias_sat     = clamp(int'(sample), BiasMin, BiasMax);
        seg_clamped  = (offset_sat != int'(prev_q)) || (slope_sat != int'(slope_full));
        bias_clamped = (bias_sat != int'(sample));
        seg_entry    = {OffsetWidth'(offset_sat), SlopeWidth'(slope_sat)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            setting_q    <= '0;
            k_q          <= '0;
            prev_q       <= '0;
            sat_q        <= 1'b0;
            seg_we_q     <= 1'b0;
            seg_waddr_q  <= '0;
            seg_wdata_q  <= '0;
            bias_we_q    <= 1'b0;
            bias_waddr_q <= '0;
            bias_wdata_q <= '0;
            done_q       <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-raised below.
            seg_we_q  <= 1'b0;
            bias_we_q <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start_i) begin
                        setting_q <= start_setting_i;
                        sat_q     <= 1'b0;
                        k_q       <= '0;
                        state_q   <= StFirst;
                    end
                end
                StFirst: begin
                    if (accept) begin
                        prev_q  <= sample;
                        state_q <= StSeg;
                    end
                end
                StSeg: begin
                    if (accept) begin
                        seg_we_q    <= 1'b1;
                        seg_waddr_q <= {setting_q, k_q};
                        seg_wdata_q <= seg_entry;
                        prev_q      <= sample;
                        if (seg_clamped) sat_q <= 1'b1;
                        // k is all ones on the last entry; hold it rather than wrap.
                        if (&k_q) begin
                            state_q <= StBias;
                        end else begin
                            k_q <= k_q + 1'b1;
                        end
                    end
                end
                StBias: begin
                    if (accept) begin
                        bias_we_q    <= 1'b1;
                        bias_waddr_q <= setting_q;
                        bias_wdata_q <= BiasWidth'(bias_sat);
                        if (bias_clamped) sat_q <= 1'b1;
                        done_q       <= 1'b1;
                        state_q      <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign seg_we_o     = seg_we_q;
    assign seg_waddr_o  = seg_waddr_q;
    assign seg_wdata_o  = seg_wdata_q;
    assign bias_we_o    = bias_we_q;
    assign bias_waddr_o = bias_waddr_q;
    assign bias_wdata_o = bias_wdata_q;
    assign busy_o       = (state_q != StIdle);
    assign done_o       = done_q;
    assign sat_flag_o   = sat_q;

endmodule

// File: doc/pwl_table_writer.md
# pwl_table_writer

Runtime loader for the piecewise-linear evaluator's coefficient memories. It accepts a stream of breakpoint samples y[0..N] for one setting, where N = 2^addr_width, and encodes them into segment entries {offset, slope}. Each entry has offset = y[k] and slope = (y[k+1]−y[k]) scaled by 2^slope_shift. It then writes one bias word. The block drives the write ports of the segment and bias RAMs, whose read ports feed the PWL evaluator, so filter and path responses can be reprogrammed without re-synthesising ROM images.

## Interface
- setting_width, 1, width of the setting index (bias RAM address)
- addr_width, 2, segment index width; N = 2^addr_width segments per setting
- sample_width, 8, signed width of breakpoint samples and bias input word
- offset_width, 8, signed width of stored offset
- slope_width, 6, signed width of stored slope
- slope_shift, 1, left shift applied to sample difference (≥0); encodes the evaluator's segment length and point alignment
- bias_width, 8, signed width of stored bias

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a load session (honoured only in IDLE)
- start_setting  in  setting_width  setting captured on accepted start
- in_valid  in  1  sample/bias word valid
- in_ready  out  1  block can accept in_data
- in_data  in  sample_width  signed sample, then bias word
- seg_we  out  1  segment RAM write enable
- seg_waddr  out  setting_width+addr_width  {setting, k}
- seg_wdata  out  offset_width+slope_width  {offset, slope}, offset in MSBs
- bias_we  out  1  bias RAM write enable
- bias_waddr  out  setting_width  setting
- bias_wdata  out  bias_width  signed bias
- busy  out  1  session in progress
- done  out  1  one-cycle pulse, session complete
- sat_flag  out  1  sticky: a clamp occurred in the current or last session

## Operation
- States: IDLE, FIRST, SEG, BIAS.
- IDLE: in_ready=0. start=1 latches start_setting, clears sat_flag, sets k=0, and moves to FIRST.
- FIRST: in_ready=1. Accepted word goes to register prev; no write. Moves to SEG.
- SEG: in_ready=1. Each accepted word y:
  - Write entry k: offset=clamp(prev, offset_width), slope=clamp((y−prev)·2^slope_shift, slope_width).
  - prev←y, k←k+1.
  - After entry k=N−1 is written, move to BIAS.
- BIAS: in_ready=1. Accepted word writes bias_wdata=clamp(in_data, bias_width) at bias_waddr=setting; the block returns to IDLE.
- Arithmetic:
  - Difference computed at sample_width+1 bits, then shifted at sample_width+1+slope_shift bits; no wrap.
  - Clamp means saturate to [−2^(w−1), 2^(w−1)−1].
  - Any clamp sets sat_flag.
- start outside IDLE is ignored. in_data with in_ready=0 is ignored.
- k never wraps within a session; the transition to BIAS occurs exactly at N entries.

## Timing
- Reset values: state IDLE; all outputs 0; k=0; sat_flag=0; address and data registers 0.
- rst mid-session aborts the session. No write strobe is asserted from the cycle after the reset edge. A partially loaded setting is left as is.
- in_ready is a function of registered state only and does not depend on in_valid.
- Accept occurs on the edge where in_valid & in_ready = 1. Throughput is one word per cycle.
- start accepted at edge t: busy=1 and in_ready=1 from t+1.
- Sample j (1..N) accepted at edge t: seg_we=1 for exactly the cycle after t, with waddr/wdata valid that cycle.
- Bias accepted at edge t: in the following cycle bias_we=1, done=1, busy=0, state=IDLE. A start in that cycle is accepted.
- Minimum session length: N+2 accepts plus the start cycle.

## Test plan
- Defaults, setting 1: samples 10,20,25,25,15 then bias −3 -> seg writes (addr 4,{10,20}), (5,{20,10}), (6,{25,0}), (7,{25,−20}); bias_we addr 1 data −3; done pulse; sat_flag=0.
- Saturation: samples 0,100,100,100,100 -> entry 0 slope=31 (200 clamped); sat_flag=1 persisting after done until the next start.
- in_valid toggling 1,0,0,1,… during SEG -> seg_we only on cycles after accepts; addresses contiguous; no duplicate or missing entries.
- start pulsed during SEG with a different start_setting -> ignored; waddr keeps the original setting.
- rst asserted after two SEG writes -> no further seg_we/bias_we; busy=0. A new session writes from k=0 correctly.
- Back-to-back: start asserted in the done cycle with setting 0 -> second session runs with busy=1 the next cycle and writes addresses 0..3 and bias addr 0.
